// File: rtl/huffman_pkg.sv
// huffman_pkg: shared widths, table entry field positions and FSM state encoding
package huffman_pkg;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 12;
  localparam int LEN_W   = 4;
  localparam int CODE_W  = 8;
  localparam int MAX_LEN = 8;
  localparam int LEN_LO  = 8;
  localparam int CODE_LO = 0;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_e;
endpackage

// File: rtl/huffman_if.sv
// huffman_if: symbol input, table read port and serial output bundle
// master: symbol source / table / bit sink side; slave: the encoder
interface huffman_if #(
  parameter int ADDR_W = huffman_pkg::ADDR_W,
  parameter int DATA_W = huffman_pkg::DATA_W
);
  logic [ADDR_W-1:0] sym;
  logic              sym_valid;
  logic              sym_ready;
  logic              mem_modeselect;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              ser_bit;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_last;
  logic              err;
  modport master (
    output sym, sym_valid, mem_data, ser_ready,
    input  sym_ready, mem_modeselect, mem_addr, ser_bit, ser_valid, ser_last, err
  );
  modport slave (
    input  sym, sym_valid, mem_data, ser_ready,
    output sym_ready, mem_modeselect, mem_addr, ser_bit, ser_valid, ser_last, err
  );
endinterface

// File: rtl/huffman_shifter.sv
// huffman_shifter: MSB-first code serializer with valid/ready output handshake
// load_i/len_i/code_i start a code; ser_*_o are registered; done_o flags the last-bit handshake
module huffman_shifter import huffman_pkg::*; (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              ser_ready_i,
  output logic              ser_bit_o,
  output logic              ser_valid_o,
  output logic              ser_last_o,
  output logic              done_o
);
  logic [CODE_W-1:0] sh_q, sh_d, aligned;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              bit_q, bit_d, valid_q, valid_d, last_q, last_d, adv;
  // left-justify the code so its top bit is always at the MSB
  assign aligned = code_i << (LEN_W'(CODE_W) - len_i);
  assign adv     = valid_q & ser_ready_i;
  assign done_o  = adv & last_q;
  always_comb begin
    sh_d    = load_i ? aligned << 1 : adv ? sh_q << 1 : sh_q;
    bit_d   = load_i ? aligned[CODE_W-1] : adv ? sh_q[CODE_W-1] : bit_q;
    cnt_d   = load_i ? len_i : adv ? cnt_q - 1'b1 : cnt_q;
    valid_d = load_i ? 1'b1 : adv ? cnt_q != LEN_W'(1) : valid_q;
    last_d  = load_i ? len_i == LEN_W'(1) : adv ? cnt_q == LEN_W'(2) : last_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign ser_bit_o   = bit_q;
  assign ser_valid_o = valid_q;
  assign ser_last_o  = last_q;
endmodule

// File: rtl/huffman_tx.sv
// huffman_tx: table-driven Huffman encoder emitting one code bit per handshake
// clock/reset_n plain ports; bus (slave) carries sym, table read port, serial output and err
module huffman_tx #(
  parameter int ADDR_W  = huffman_pkg::ADDR_W,
  parameter int DATA_W  = huffman_pkg::DATA_W,
  parameter int MAX_LEN = huffman_pkg::MAX_LEN
) (
  input logic      clock,
  input logic      reset_n,
  huffman_if.slave bus
);
  import huffman_pkg::*;
  state_e            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              err_q, legal, load, done;
  logic [DATA_W-1:0] entry;
  logic [LEN_W-1:0]  len;
  logic [CODE_W-1:0] code;
  assign entry = bus.mem_data;
  assign len   = entry[LEN_LO +: LEN_W];
  assign code  = entry[CODE_LO +: CODE_W];
  assign legal = len != '0 && int'(len) <= MAX_LEN;
  assign load  = state_q == LOAD && legal;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.sym_valid) begin
          mem_addr_q <= bus.sym;
          state_q    <= FETCH;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          state_q <= legal ? SHIFT : IDLE;
          err_q   <= !legal;
        end
        SHIFT: if (done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // gated by reset_n so the block refuses symbols while held in reset
  assign bus.sym_ready      = reset_n && state_q == IDLE;
  assign bus.mem_modeselect = 1'b0;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.err            = err_q;
  huffman_shifter u_shift (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_i      (load),
    .len_i       (len),
    .code_i      (code),
    .ser_ready_i (bus.ser_ready),
    .ser_bit_o   (bus.ser_bit),
    .ser_valid_o (bus.ser_valid),
    .ser_last_o  (bus.ser_last),
    .done_o      (done)
  );
endmodule

// File: tb/tb_huffman_tx.sv
// tb_huffman_tx: directed and randomized checks of huffman_tx against a bit-list reference model
module tb_huffman_tx;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [11:0] tbl [64];
  huffman_if bus ();
  huffman_tx dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock = ~clock;
  always @(posedge clock) bus.mem_data <= tbl[bus.mem_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(bus.ser_valid), 0);
    chk({tag, "_bit"}, 32'(bus.ser_bit), 0);
    chk({tag, "_last"}, 32'(bus.ser_last), 0);
    chk({tag, "_modesel"}, 32'(bus.mem_modeselect), 0);
  endtask
  // mode: 0 ready high, 1 ready toggling 1,0,..., 2 random ready
  // hold: keep sym_valid high with junk sym while busy
  // abort_after: pulse reset once this many bits were accepted (-1 = never)
  task automatic run_sym(input logic [5:0] s, input int mode, input bit hold, input int abort_after);
    logic [11:0] e;
    logic [7:0] code;
    int len, left, cyc;
    bit legal, rdy;
    e = tbl[s];
    len = int'(e[11:8]);
    code = e[7:0];
    legal = len >= 1 && len <= 8;
    chk("idle_ready", 32'(bus.sym_ready), 1);
    chk_quiet("idle");
    bus.sym = s;
    bus.sym_valid = 1'b1;
    bus.ser_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    bus.sym_valid = hold;
    bus.sym = 6'($urandom);
    chk("fetch_ready", 32'(bus.sym_ready), 0);
    chk("fetch_addr", 32'(bus.mem_addr), 32'(s));
    chk("fetch_valid", 32'(bus.ser_valid), 0);
    @(negedge clock);
    bus.sym = 6'($urandom);
    chk("load_ready", 32'(bus.sym_ready), 0);
    chk("load_valid", 32'(bus.ser_valid), 0);
    chk("load_err", 32'(bus.err), 0);
    @(negedge clock);
    if (!legal) begin
      bus.sym_valid = 1'b0;
      chk("err_pulse", 32'(bus.err), 1);
      chk("err_valid", 32'(bus.ser_valid), 0);
      chk("err_idle_ready", 32'(bus.sym_ready), 1);
      @(negedge clock);
      chk("err_clear", 32'(bus.err), 0);
      chk("err_valid2", 32'(bus.ser_valid), 0);
      return;
    end
    left = len;
    cyc = 0;
    while (left > 0 && cyc < 8 * len + 16) begin
      chk("bit_valid", 32'(bus.ser_valid), 1);
      chk("bit_value", 32'(bus.ser_bit), 32'(code[left-1]));
      chk("bit_last", 32'(bus.ser_last), 32'(left == 1));
      chk("bit_err", 32'(bus.err), 0);
      chk("bit_ready", 32'(bus.sym_ready), 0);
      chk("bit_modesel", 32'(bus.mem_modeselect), 0);
      if (abort_after >= 0 && len - left == abort_after) begin
        reset_n = 1'b0;
        bus.sym_valid = 1'b0;
        bus.ser_ready = 1'b1;
        #1;
        chk_quiet("rst");
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ready", 32'(bus.sym_ready), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.sym_ready), 1);
        for (int k = 0; k < 12; k++) begin
          @(negedge clock);
          chk("post_rst_valid", 32'(bus.ser_valid), 0);
        end
        return;
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      bus.ser_ready = rdy;
      if (hold) bus.sym = 6'($urandom);
      if (rdy) left--;
      cyc++;
      @(negedge clock);
    end
    chk("bits_left", 32'(left), 0);
    chk("end_ready", 32'(bus.sym_ready), 1);
    chk_quiet("end");
  endtask
  initial begin
    bus.sym = '0;
    bus.sym_valid = 1'b0;
    bus.ser_ready = 1'b0;
    for (int i = 0; i < 64; i++) tbl[i] = {4'($urandom_range(0, 9)), 8'($urandom)};
    tbl[0] = 12'h000;
    tbl[1] = 12'h9FF;
    tbl[2] = 12'h101;
    tbl[5] = 12'h305;
    tbl[63] = 12'h8A5;
    #3;
    chk("reset_ready", 32'(bus.sym_ready), 0);
    chk("reset_addr", 32'(bus.mem_addr), 0);
    chk("reset_err", 32'(bus.err), 0);
    chk_quiet("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("release_ready", 32'(bus.sym_ready), 1);
    @(negedge clock);
    run_sym(6'd5, 0, 1'b0, -1);
    run_sym(6'd63, 1, 1'b0, -1);
    run_sym(6'd0, 0, 1'b0, -1);
    run_sym(6'd1, 0, 1'b0, -1);
    run_sym(6'd2, 0, 1'b0, -1);
    run_sym(6'd63, 0, 1'b0, 2);
    run_sym(6'd5, 0, 1'b1, -1);
    run_sym(6'd2, 0, 1'b1, -1);
    run_sym(6'd5, 0, 1'b1, -1);
    bus.sym_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.sym_valid = 1'b0;
        @(negedge clock);
      end
      run_sym(6'($urandom), 2, 1'($urandom_range(0, 1)), -1);
    end
    bus.sym_valid = 1'b0;
    @(negedge clock);
    chk("final_ready", 32'(bus.sym_ready), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
